// File: rtl/pio_gpio_in_cond.sv
// pio_gpio_in_cond: pad synchroniser, per-pin deglitch filter and sticky edge-event register for PIO gpio_in
module pio_gpio_in_cond #(
  parameter int NPIN = 32,
  parameter int CW = 8,
  parameter logic [NPIN-1:0] RST_VAL = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NPIN-1:0] pad_in,
  input  logic [NPIN-1:0] filt_en,
  input  logic [CW-1:0]   filt_len,
  input  logic [NPIN-1:0] rise_en,
  input  logic [NPIN-1:0] fall_en,
  input  logic [NPIN-1:0] evt_clr,
  output logic [NPIN-1:0] gpio_in,
  output logic [NPIN-1:0] rise,
  output logic [NPIN-1:0] fall,
  output logic [NPIN-1:0] evt_status,
  output logic            irq
);
  logic [NPIN-1:0] s1, s2, filt_q, filt_d;
  // two-flop synchroniser, delayed filter output for edge detect, sticky events where set beats clear
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
      filt_d <= RST_VAL;
      evt_status <= '0;
    end else begin
      s1 <= pad_in;
      s2 <= s1;
      filt_d <= filt_q;
      evt_status <= (evt_status & ~evt_clr) | (rise & rise_en) | (fall & fall_en);
    end
  end
  for (genvar j = 0; j < NPIN; j++) begin : g_pin
    logic q;
    logic [CW-1:0] c;
    // commit s2 once it has differed from the filtered level for filt_len+1 consecutive samples
    always_ff @(posedge clk) begin
      if (reset) begin
        q <= RST_VAL[j];
        c <= '0;
      end else if (!filt_en[j] || (s2[j] != q && c >= filt_len)) begin
        q <= s2[j];
        c <= '0;
      end else begin
        c <= (s2[j] == q) ? '0 : c + 1'b1;
      end
    end
    assign filt_q[j] = q;
  end
  assign gpio_in = filt_q;
  assign rise = filt_q & ~filt_d;
  assign fall = ~filt_q & filt_d;
  assign irq = |evt_status;
endmodule

// File: tb/tb_pio_gpio_in_cond.sv
// tb_pio_gpio_in_cond: vector table, directed corner sequences and randomized run against a run-length reference model
module tb_pio_gpio_in_cond;
  logic clk = 0;
  logic reset;
  logic [31:0] pad_in, filt_en, rise_en, fall_en, evt_clr;
  logic [7:0] filt_len;
  logic [31:0] gpio_in, rise, fall, evt_status;
  logic irq;
  int n_chk = 0, n_fail = 0;
  logic [31:0] m1, m2, mq, mqd, mev;
  int run [32];
  typedef struct {
    logic [31:0] pad;
    logic [31:0] fen;
    logic [7:0]  len;
    int          hold;
    logic [31:0] exp;
  } vec_t;
  vec_t tv [8];

  always #5 clk = ~clk;

  pio_gpio_in_cond dut (
    .clk(clk), .reset(reset), .pad_in(pad_in), .filt_en(filt_en), .filt_len(filt_len),
    .rise_en(rise_en), .fall_en(fall_en), .evt_clr(evt_clr), .gpio_in(gpio_in),
    .rise(rise), .fall(fall), .evt_status(evt_status), .irq(irq)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a change on the synchronised pin is accepted once it has been seen
  // on filt_len+1 consecutive samples; any return to the current level restarts the run.
  task automatic model_edge();
    logic [31:0] r, f;
    r = mq & ~mqd;
    f = ~mq & mqd;
    if (reset) begin
      m1 = 0; m2 = 0; mq = 0; mqd = 0; mev = 0;
      for (int j = 0; j < 32; j++) run[j] = 0;
    end else begin
      mev = (mev & ~evt_clr) | (r & rise_en) | (f & fall_en);
      mqd = mq;
      for (int j = 0; j < 32; j++) begin
        if (!filt_en[j]) begin
          mq[j] = m2[j];
          run[j] = 0;
        end else if (m2[j] == mq[j]) begin
          run[j] = 0;
        end else begin
          run[j]++;
          if (run[j] > int'(filt_len)) begin
            mq[j] = m2[j];
            run[j] = 0;
          end
        end
      end
      m2 = m1;
      m1 = pad_in;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("gpio_in", gpio_in, mq);
    chk("rise", rise, mq & ~mqd);
    chk("fall", fall, ~mq & mqd);
    chk("evt_status", evt_status, mev);
    chk("irq", {31'b0, irq}, {31'b0, |mev});
  endtask

  task automatic cyc(input int n);
    repeat (n) tick();
  endtask

  initial begin
    tv[0] = '{32'hFFFF_FFFF, 32'h0, 8'd0, 3, 32'hFFFF_FFFF};
    tv[1] = '{32'h0, 32'h0, 8'd0, 2, 32'hFFFF_FFFF};
    tv[2] = '{32'h0, 32'h0, 8'd0, 1, 32'h0};
    tv[3] = '{32'hA5A5_A5A5, 32'hFFFF_FFFF, 8'd2, 4, 32'h0};
    tv[4] = '{32'hA5A5_A5A5, 32'hFFFF_FFFF, 8'd2, 1, 32'hA5A5_A5A5};
    tv[5] = '{32'h0, 32'hFFFF_0000, 8'd5, 3, 32'hA5A5_0000};
    tv[6] = '{32'h0, 32'hFFFF_0000, 8'd5, 4, 32'hA5A5_0000};
    tv[7] = '{32'h0, 32'hFFFF_0000, 8'd5, 1, 32'h0};
    reset = 1; pad_in = '1; filt_en = 0; filt_len = 0; rise_en = 0; fall_en = 0; evt_clr = 0;
    m1 = 0; m2 = 0; mq = 0; mqd = 0; mev = 0;
    for (int j = 0; j < 32; j++) run[j] = 0;
    repeat (4) begin
      tick();
      chk("reset_gpio", gpio_in, 32'h0);
      chk("reset_edges", rise | fall, 32'h0);
      chk("reset_irq", {31'b0, irq}, 32'h0);
    end
    reset = 0;
    for (int i = 0; i < 8; i++) begin
      pad_in = tv[i].pad; filt_en = tv[i].fen; filt_len = tv[i].len;
      cyc(tv[i].hold);
      chk($sformatf("vec%0d", i), gpio_in, tv[i].exp);
    end
    // bypass latency and single-cycle rise
    filt_en = 0; pad_in = 0; cyc(4);
    pad_in[5] = 1; cyc(2);
    chk("bypass_early", {31'b0, gpio_in[5]}, 32'h0);
    tick();
    chk("bypass_gpio", {31'b0, gpio_in[5]}, 32'h1);
    chk("bypass_rise", rise, 32'h20);
    tick();
    chk("bypass_rise_end", rise, 32'h0);
    // deglitch: pulses of 1..4 samples rejected, 5 accepted at edge k+7
    filt_en = 32'h1; filt_len = 4; pad_in = 0; cyc(4);
    for (int w = 1; w <= 4; w++) begin
      pad_in[0] = 1; cyc(w);
      pad_in[0] = 0; cyc(10);
      chk($sformatf("deglitch_w%0d", w), {31'b0, gpio_in[0]}, 32'h0);
    end
    pad_in[0] = 1; cyc(5);
    pad_in[0] = 0; cyc(1);
    chk("deglitch_w5_early", {31'b0, gpio_in[0]}, 32'h0);
    tick();
    chk("deglitch_w5", {31'b0, gpio_in[0]}, 32'h1);
    cyc(12);
    // glitch restart
    filt_en = 32'h4; filt_len = 3; pad_in = 0; cyc(4);
    pad_in[2] = 1; cyc(3);
    pad_in[2] = 0; cyc(1);
    pad_in[2] = 1; cyc(5);
    chk("restart_early", {31'b0, gpio_in[2]}, 32'h0);
    tick();
    chk("restart_commit", {31'b0, gpio_in[2]}, 32'h1);
    pad_in[2] = 0; cyc(8);
    // events: rise captured, fall ignored, set beats clear, lone clear
    filt_en = 0; rise_en = 32'h80; fall_en = 0; pad_in = 0; cyc(4);
    pad_in[7] = 1; cyc(3);
    tick();
    chk("evt_rise", evt_status, 32'h80);
    chk("evt_irq", {31'b0, irq}, 32'h1);
    pad_in[7] = 0; cyc(6);
    chk("evt_fall_ignored", evt_status, 32'h80);
    pad_in[7] = 1; cyc(3);
    evt_clr = 32'h80; tick(); evt_clr = 0;
    chk("evt_set_wins", evt_status, 32'h80);
    evt_clr = 32'h80; tick(); evt_clr = 0;
    chk("evt_clear", evt_status, 32'h0);
    chk("evt_clear_irq", {31'b0, irq}, 32'h0);
    // mid-operation changes
    rise_en = 0; pad_in = 0; filt_en = 32'h2; filt_len = 200; cyc(4);
    pad_in[1] = 1; cyc(52);
    chk("len_pending", {31'b0, gpio_in[1]}, 32'h0);
    filt_len = 10; tick();
    chk("len_lowered", {31'b0, gpio_in[1]}, 32'h1);
    filt_len = 200; pad_in[1] = 0; cyc(20);
    chk("en_pending", {31'b0, gpio_in[1]}, 32'h1);
    filt_en[1] = 0; tick();
    chk("en_dropped", {31'b0, gpio_in[1]}, 32'h0);
    rise_en = '1; pad_in = 32'hFFFF_0000; cyc(5);
    filt_en = '1; pad_in = 0; cyc(10);
    reset = 1; tick(); reset = 0;
    chk("midreset_gpio", gpio_in, 32'h0);
    chk("midreset_evt", evt_status, 32'h0);
    // randomized run
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) begin
        filt_len = 8'($urandom_range(0, 6));
        filt_en = $urandom;
        rise_en = $urandom;
        fall_en = $urandom;
      end
      pad_in = pad_in ^ ($urandom & $urandom & $urandom);
      evt_clr = ($urandom_range(0, 7) == 0) ? $urandom : 32'h0;
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
